// File: rtl/axil_cfg_sequencer.sv
// axil_cfg_sequencer: AXI-Lite master that walks a command table after a start
// pulse, issuing one write per entry and optionally reading it back to verify.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   start                    one-cycle pulse, begins the run at entry 0
//   busy / done / error      run in progress / finished OK pulse / aborted pulse
//   err_code, err_idx        cause (1 BRESP, 2 RRESP, 3 timeout, 4 mismatch) and entry of last abort
//   tbl_idx                  entry being processed; tbl_op/tbl_addr/tbl_data answer combinationally
//   aw*, w*, b*, ar*, r*     AXI-Lite master write and read channels
module axil_cfg_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code,
    output logic [IDX_W-1:0]  err_idx,
    output logic [IDX_W-1:0]  tbl_idx,
    input  logic [1:0]        tbl_op,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;
    localparam logic [2:0] ERR_BRESP = 3'd1;
    localparam logic [2:0] ERR_RRESP = 3'd2;
    localparam logic [2:0] ERR_TMO   = 3'd3;
    localparam logic [2:0] ERR_CMP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WR, S_WRESP, S_RADDR, S_RDATA, S_NEXT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               verify_q, verify_d;

    logic               busy_d, done_d, error_d;
    logic [2:0]         err_code_d;
    logic [IDX_W-1:0]   err_idx_d, tbl_idx_d;
    logic [ADDR_W-1:0]  awaddr_d, araddr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic               awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;

    logic               abort, finish, timeout_hit, aw_ok, w_ok;
    logic [2:0]         abort_code;

    // Last waiting cycle before the phase budget runs out.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        verify_d   = verify_q;
        busy_d     = busy;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code;
        err_idx_d  = err_idx;
        tbl_idx_d  = tbl_idx;
        awaddr_d   = awaddr;
        awvalid_d  = awvalid;
        wdata_d    = wdata;
        wvalid_d   = wvalid;
        bready_d   = bready;
        araddr_d   = araddr;
        arvalid_d  = arvalid;
        rready_d   = rready;
        abort      = 1'b0;
        finish     = 1'b0;
        abort_code = 3'd0;
        aw_ok      = 1'b0;
        w_ok       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    tbl_idx_d = '0;
                    busy_d    = 1'b1;
                end
            end
            S_FETCH: begin
                if (tbl_op[1]) begin
                    finish = 1'b1;
                end else begin
                    verify_d  = tbl_op[0];
                    awaddr_d  = tbl_addr;
                    wdata_d   = tbl_data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                // A channel whose valid is already low has completed its handshake.
                aw_ok = !awvalid || awready;
                w_ok  = !wvalid || wready;
                if (awvalid && awready) awvalid_d = 1'b0;
                if (wvalid && wready)   wvalid_d  = 1'b0;
                if (aw_ok && w_ok) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    abort_code = ERR_TMO;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    if (bresp != 2'b00) begin
                        abort      = 1'b1;
                        abort_code = ERR_BRESP;
                    end else if (verify_q) begin
                        araddr_d  = awaddr;
                        arvalid_d = 1'b1;
                        state_d   = S_RADDR;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    abort_code = ERR_TMO;
                end
            end
            S_RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    abort_code = ERR_TMO;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    // Response error outranks a data mismatch in the same beat.
                    if (rresp != 2'b00) begin
                        abort      = 1'b1;
                        abort_code = ERR_RRESP;
                    end else if (rdata != wdata) begin
                        abort      = 1'b1;
                        abort_code = ERR_CMP;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    abort_code = ERR_TMO;
                end
            end
            S_NEXT: begin
                if (tbl_idx == LAST_IDX) begin
                    finish = 1'b1;
                end else begin
                    tbl_idx_d = tbl_idx + IDX_W'(1);
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        // Abort leaves the bus quiet; the slave is recovered by system reset.
        if (abort) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = abort_code;
            err_idx_d  = tbl_idx;
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
        end

        // Phase counter restarts on every state entry, runs only while waiting on the slave.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {S_WR, S_WRESP, S_RADDR, S_RDATA}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            verify_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 3'd0;
            err_idx  <= '0;
            tbl_idx  <= '0;
            awaddr   <= '0;
            awvalid  <= 1'b0;
            wdata    <= '0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            araddr   <= '0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            verify_q <= verify_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            err_code <= err_code_d;
            err_idx  <= err_idx_d;
            tbl_idx  <= tbl_idx_d;
            awaddr   <= awaddr_d;
            awvalid  <= awvalid_d;
            wdata    <= wdata_d;
            wvalid   <= wvalid_d;
            bready   <= bready_d;
            araddr   <= araddr_d;
            arvalid  <= arvalid_d;
            rready   <= rready_d;
        end
    end

endmodule

// File: doc/axil_cfg_sequencer.md
Name:
axil_cfg_sequencer

Overview:
- AXI-Lite master that configures the axi_lite_slave register block from a table of commands after a start pulse.
- Each table entry is a write, or a write followed by a readback compare.
- Sits between the system control logic (start/status) and the slave's AXI-Lite write and read channels.
- One transaction is outstanding at a time; on error the run aborts with an error code.

Parameters:
- ADDR_W, 32, AXI-Lite address width.
- DATA_W, 32, AXI-Lite data width.
- IDX_W, 4, table index width; table depth = 2**IDX_W.
- TIMEOUT, 255, maximum wait cycles per handshake phase before abort.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- start  in  1  one-cycle pulse; begin sequence at entry 0
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse; sequence finished OK
- error  out  1  one-cycle pulse; sequence aborted
- err_code  out  3  cause of last abort: 0 none, 1 BRESP, 2 RRESP, 3 timeout, 4 verify mismatch
- err_idx  out  IDX_W  entry index of the last abort
- tbl_idx  out  IDX_W  current table entry index
- tbl_op  in  2  00 write, 01 write+verify, 1x end-of-list; combinational from tbl_idx, same cycle
- tbl_addr  in  ADDR_W  entry address
- tbl_data  in  DATA_W  entry data / expected readback
- awaddr, awvalid  out  ADDR_W, 1 / awready  in  1  write address channel
- wdata, wvalid  out  DATA_W, 1 / wready  in  1  write data channel
- bresp  in  2 / bvalid  in  1 / bready  out  1  write response channel
- araddr, arvalid  out  ADDR_W, 1 / arready  in  1  read address channel
- rdata  in  DATA_W / rresp  in  2 / rvalid  in  1 / rready  out  1  read data channel

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state IDLE. Reset mid-run abandons the transaction immediately with no done/error pulse.
- IDLE: on start, go to FETCH with tbl_idx=0 and busy=1. start while busy is ignored.
- FETCH (1 cycle): sample tbl_op, tbl_addr, tbl_data.
  - op 1x: go to IDLE, busy=0, pulse done.
  - otherwise: go to WR and assert awvalid and wvalid the next cycle, with awaddr=tbl_addr and wdata=tbl_data.
- WR: awvalid and wvalid are held independently until each handshake completes (valid&&ready); either may complete first or both in the same cycle. When both are done, go to WRESP. awaddr and wdata stay stable while valid.
- WRESP: bready=1. On bvalid:
  - bresp!=0: abort, code 1.
  - op 00: go to NEXT.
  - op 01: go to RADDR.
- RADDR: arvalid=1, araddr=latched address, until arready; then go to RDATA.
- RDATA: rready=1. On rvalid:
  - rresp!=0: abort, code 2.
  - rdata!=latched data: abort, code 4.
  - otherwise: go to NEXT.
- NEXT:
  - tbl_idx == 2**IDX_W-1: finish as for op 1x, so a table with no end marker completes after the last entry.
  - else: tbl_idx+1, go to FETCH.
- Timeout:
  - An 8-bit-or-wider counter clears on each state entry and increments in WR, WRESP, RADDR and RDATA.
  - Count reaching TIMEOUT aborts with code 3 and drops all valid/ready outputs; slave recovery is by system reset.
- Abort: err_code and err_idx latch the cause and the current tbl_idx; pulse error; busy=0; go to IDLE.
  - err_code and err_idx hold until the next abort or reset; a new start does not clear them.
- Error priority in one cycle: response error > mismatch.
- Per-entry latency with zero-wait slave:
  - Write: 4 cycles (FETCH, WR, WRESP, NEXT).
  - Write+verify: 6 cycles.

Test Plan:
- Entries {00,0x10,0xA5}, {00,0x14,0x5A}, {1x}; slave always ready -> 2 writes in order; done pulse ~9 cycles after start; busy low afterward.
- Entry {01,0x20,0x1234}; slave returns rdata=0x1234 -> done. Repeat with rdata=0x1235 -> error, err_code=4, err_idx=0.
- awready delayed 3 cycles while wready immediate; then the reverse -> each valid drops only after its own handshake; exactly one write per entry.
- bresp=2'b10 on entry 1 -> error, err_code=1, err_idx=1; no AW for entry 2.
- awready never asserted with TIMEOUT=255 -> error and err_code=3 exactly 255 cycles after awvalid rises; start pulse while busy is ignored.
- All 16 entries op 00, no end marker -> 16 writes, then done. Assert reset_n low during entry 5 -> all outputs 0 asynchronously; no done or error pulse.
